fft_iter_stage_controller: RTL and testbench



---
 rtl/fft_ctrl_pkg.sv | 18 +
 rtl/fft_addr_gen.sv | 31 +++
 rtl/fft_iter_stage_controller.sv | 177 +++++++++++++++++
 tb/tb_fft_iter_stage_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types and constants for the iterative FFT stage sequencer
package fft_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      FLUSH = 3'd2,
      WB    = 3'd3,
      DONE  = 3'd4
   } ctrl_state_e;

   localparam int SLOT_LEN_DEF = 5;

   function automatic int N_OF(input int log2n);
      return 1 << log2n;
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - combinational (stage, butterfly) -> operand and twiddle addresses
module fft_addr_gen #(
   parameter int LOG2N = 4
) (
   input  logic [LOG2N-1:0] s_i,
   input  logic [LOG2N-2:0] j_i,
   output logic [LOG2N-1:0] a_o,
   output logic [LOG2N-1:0] b_o,
   output logic [LOG2N-2:0] tw_o
);

   localparam logic [LOG2N-1:0] ONE   = LOG2N'(1);
   localparam logic [LOG2N-1:0] TOP_S = LOG2N'(LOG2N - 1);

   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] grp;
   logic [LOG2N-2:0] pos_mask;
   logic [LOG2N-2:0] pos;

   // pos is j modulo span; grp selects which 2*span block the pair sits in
   always_comb begin
      span     = ONE << s_i;
      pos_mask = ~({(LOG2N-1){1'b1}} << s_i);
      pos      = j_i & pos_mask;
      grp      = {1'b0, j_i} >> s_i;
      a_o      = (grp << (s_i + ONE)) | {1'b0, pos};
      b_o      = a_o + span;
      tw_o     = pos << (TOP_S - s_i);
   end

endmodule

// File: rtl/fft_iter_stage_controller.sv
// rtl/fft_iter_stage_controller.sv - stage/butterfly sequencer for the in-place radix-2 DIT FFT engine
module fft_iter_stage_controller
   import fft_ctrl_pkg::*;
#(
   parameter int LOG2N    = 4,
   parameter int SLOT_LEN = SLOT_LEN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             bf_strb,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);

   localparam int               N         = N_OF(LOG2N);
   localparam int               SW        = $clog2(SLOT_LEN);
   localparam logic [SW-1:0]    SLOT_LAST = SW'(SLOT_LEN - 1);
   localparam logic [SW-1:0]    SLOT_WB   = SW'(1);
   localparam logic [LOG2N-2:0] J_LAST    = (LOG2N-1)'(N / 2 - 1);
   localparam logic [LOG2N-1:0] S_LAST    = LOG2N'(LOG2N - 1);

   ctrl_state_e      state_q, state_d;
   logic [SW-1:0]    slot_q, slot_d;
   logic [LOG2N-2:0] j_q, j_d;
   logic [LOG2N-1:0] s_q, s_d;
   logic [LOG2N-1:0] wa_q, wa_d;
   logic [LOG2N-1:0] wb_q, wb_d;

   logic [LOG2N-1:0] gen_a;
   logic [LOG2N-1:0] gen_b;
   logic [LOG2N-2:0] gen_tw;

   fft_addr_gen #(
      .LOG2N (LOG2N)
   ) u_addr_gen (
      .s_i  (s_q),
      .j_i  (j_q),
      .a_o  (gen_a),
      .b_o  (gen_b),
      .tw_o (gen_tw)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         slot_q  <= '0;
         j_q     <= '0;
         s_q     <= '0;
         wa_q    <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         j_q     <= j_d;
         s_q     <= s_d;
         wa_q    <= wa_d;
         wb_q    <= wb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      j_d     = j_q;
      s_d     = s_q;
      wa_d    = wa_q;
      wb_d    = wb_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               slot_d  = '0;
               j_d     = '0;
               s_d     = '0;
            end
         end
         RUN: begin
            if (slot_q == SLOT_LAST) begin
               // Latch this butterfly's addresses; its result is written back during the next slot.
               wa_d = gen_a;
               wb_d = gen_b;
               if (j_q == J_LAST) begin
                  state_d = FLUSH;
               end else begin
                  j_d    = j_q + (LOG2N-1)'(1);
                  slot_d = '0;
               end
            end else begin
               slot_d = slot_q + SW'(1);
            end
         end
         FLUSH: begin
            state_d = WB;
         end
         WB: begin
            if (s_q == S_LAST) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
               s_d     = s_q + LOG2N'(1);
               j_d     = '0;
               slot_d  = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
            s_d     = '0;
            j_d     = '0;
            slot_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      stage     = '0;
      bf_strb   = 1'b0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      tw_addr   = '0;
      wr_en     = 1'b0;
      wr_addr_a = '0;
      wr_addr_b = '0;
      case (state_q)
         RUN: begin
            busy      = 1'b1;
            stage     = s_q;
            bf_strb   = (slot_q == '0);
            rd_addr_a = gen_a;
            rd_addr_b = gen_b;
            tw_addr   = gen_tw;
            if (slot_q == SLOT_WB && j_q != '0) begin
               wr_en     = 1'b1;
               wr_addr_a = wa_q;
               wr_addr_b = wb_q;
            end
         end
         FLUSH: begin
            busy      = 1'b1;
            stage     = s_q;
            bf_strb   = 1'b1;
            rd_addr_a = gen_a;
            rd_addr_b = gen_b;
            tw_addr   = gen_tw;
         end
         WB: begin
            busy      = 1'b1;
            stage     = s_q;
            rd_addr_a = gen_a;
            rd_addr_b = gen_b;
            tw_addr   = gen_tw;
            wr_en     = 1'b1;
            wr_addr_a = wa_q;
            wr_addr_b = wb_q;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_fft_iter_stage_controller.sv
// tb/tb_fft_iter_stage_controller.sv - self-checking bench for the FFT stage sequencer
module tb_fft_iter_stage_controller;

   localparam int LOG2N = 4;
   localparam int RUN_LEN = 168;

   localparam logic [31:0] M_CTL = 32'h0780_0000;
   localparam logic [31:0] M_ST  = 32'h0078_0000;
   localparam logic [31:0] M_RD  = 32'h0007_FF00;
   localparam logic [31:0] M_WR  = 32'h0000_00FF;
   localparam logic [31:0] M_ALL = 32'h07FF_FFFF;

   logic             clk;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic [LOG2N-1:0] stage;
   logic             bf_strb;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             wr_en;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;

   int n_cmp;
   int n_fail;

   logic [31:0] exp_v [0:RUN_LEN+1];
   logic [31:0] exp_m [0:RUN_LEN+1];
   logic [31:0] obs   [0:RUN_LEN+2];

   fft_iter_stage_controller #(
      .LOG2N    (LOG2N),
      .SLOT_LEN (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .stage     (stage),
      .bf_strb   (bf_strb),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .tw_addr   (tw_addr),
      .wr_en     (wr_en),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {strb, wr_en, busy, done, stage[4], rd_a[4], rd_b[4], tw[3], wr_a[4], wr_b[4]}
   function automatic logic [31:0] pk(input bit st, input bit w, input bit bz, input bit dn,
                                      input int sg, input int ra, input int rb, input int tw,
                                      input int wa, input int wb);
      return {5'd0, st, w, bz, dn, sg[3:0], ra[3:0], rb[3:0], tw[2:0], wa[3:0], wb[3:0]};
   endfunction

   function automatic logic [31:0] obs_now();
      return pk(bf_strb, wr_en, busy, done, int'(stage), int'(rd_addr_a), int'(rd_addr_b),
                int'(tw_addr), int'(wr_addr_a), int'(wr_addr_b));
   endfunction

   task automatic build_model();
      int t, span, g, p, a, b, tw, pa, pb;
      bit wr;
      t = 0; a = 0; b = 0; tw = 0;
      for (int s = 0; s < LOG2N; s++) begin
         pa = 0; pb = 0;
         for (int j = 0; j < (1 << LOG2N) / 2; j++) begin
            span = 1 << s;
            g    = j / span;
            p    = j % span;
            a    = g * 2 * span + p;
            b    = a + span;
            tw   = p * (1 << (LOG2N - 1 - s));
            for (int k = 0; k < 5; k++) begin
               wr = (k == 1) && (j > 0);
               exp_v[t] = pk(k == 0, wr, 1'b1, 1'b0, s, a, b, tw, pa, pb);
               exp_m[t] = M_CTL | M_ST | M_RD | (wr ? M_WR : 32'h0);
               t++;
            end
            pa = a; pb = b;
         end
         exp_v[t] = pk(1'b1, 1'b0, 1'b1, 1'b0, s, a, b, tw, 0, 0);
         exp_m[t] = M_CTL | M_ST | M_RD;
         t++;
         exp_v[t] = pk(1'b0, 1'b1, 1'b1, 1'b0, s, 0, 0, 0, pa, pb);
         exp_m[t] = M_CTL | M_ST | M_WR;
         t++;
      end
      exp_v[t] = pk(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
      exp_m[t] = M_CTL;
      t++;
      exp_v[t] = 32'h0;
      exp_m[t] = M_ALL;
   endtask

   // Starts a transform from IDLE and records 171 cycles of outputs beginning with the first RUN cycle.
   task automatic capture_run(input bit noise, input bit done_start);
      start = 1'b1;
      @(negedge clk);
      for (int t = 0; t <= RUN_LEN + 2; t++) begin
         obs[t] = obs_now();
         if (t < RUN_LEN)          start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         else if (t < RUN_LEN + 2) start = done_start;
         else                      start = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ((obs_now() & M_ALL) !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h expected 00000000", obs_now());
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ((obs_now() & M_ALL) !== 32'h0) begin
         n_fail++;
         $display("FAIL idle_after_reset got %h expected 00000000", obs_now());
      end
   endtask

   task automatic test_full_run();
      int idx [11];
      logic [31:0] val [11];
      logic [31:0] msk [11];
      int n_strb, n_wr, n_done;
      idx[0]  = 0;   val[0]  = pk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);   msk[0]  = M_CTL | M_ST | M_RD;
      idx[1]  = 5;   val[1]  = pk(1, 0, 1, 0, 0, 2, 3, 0, 0, 0);   msk[1]  = M_CTL | M_ST | M_RD;
      idx[2]  = 6;   val[2]  = pk(0, 1, 1, 0, 0, 2, 3, 0, 0, 1);   msk[2]  = M_CTL | M_ST | M_RD | M_WR;
      idx[3]  = 47;  val[3]  = pk(1, 0, 1, 0, 1, 1, 3, 4, 0, 0);   msk[3]  = M_CTL | M_ST | M_RD;
      idx[4]  = 151; val[4]  = pk(1, 0, 1, 0, 3, 5, 13, 5, 0, 0);  msk[4]  = M_CTL | M_ST | M_RD;
      idx[5]  = 39;  val[5]  = pk(0, 0, 1, 0, 0, 14, 15, 0, 0, 0); msk[5]  = M_CTL | M_ST | M_RD;
      idx[6]  = 40;  val[6]  = pk(1, 0, 1, 0, 0, 14, 15, 0, 0, 0); msk[6]  = M_CTL | M_ST | M_RD;
      idx[7]  = 41;  val[7]  = pk(0, 1, 1, 0, 0, 0, 0, 0, 14, 15); msk[7]  = M_CTL | M_ST | M_WR;
      idx[8]  = 42;  val[8]  = pk(1, 0, 1, 0, 1, 0, 2, 0, 0, 0);   msk[8]  = M_CTL | M_ST | M_RD;
      idx[9]  = 167; val[9]  = pk(0, 1, 1, 0, 3, 0, 0, 0, 7, 15);  msk[9]  = M_CTL | M_ST | M_WR;
      idx[10] = 168; val[10] = pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);   msk[10] = M_CTL;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      capture_run(1'b0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if ((obs[idx[i]] & msk[i]) !== (val[i] & msk[i])) begin
            n_fail++;
            $display("FAIL spot_cycle_%0d got %h expected %h (mask %h)", idx[i], obs[idx[i]], val[i], msk[i]);
         end
      end
      for (int t = 0; t <= RUN_LEN + 1; t++) begin
         n_cmp++;
         if ((obs[t] & exp_m[t]) !== (exp_v[t] & exp_m[t])) begin
            n_fail++;
            $display("FAIL trace_cycle_%0d got %h expected %h (mask %h)", t, obs[t], exp_v[t], exp_m[t]);
         end
      end
      n_strb = 0; n_wr = 0; n_done = 0;
      for (int t = 0; t <= RUN_LEN + 2; t++) begin
         n_strb += int'(obs[t][26]);
         n_wr   += int'(obs[t][25]);
         n_done += int'(obs[t][23]);
      end
      n_cmp++;
      if (n_strb !== 36) begin n_fail++; $display("FAIL strobe_total got %0d expected 36", n_strb); end
      n_cmp++;
      if (n_wr !== 32) begin n_fail++; $display("FAIL wr_en_total got %0d expected 32", n_wr); end
      n_cmp++;
      if (n_done !== 1) begin n_fail++; $display("FAIL done_pulses got %0d expected 1", n_done); end
   endtask

   task automatic test_start_while_busy();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      capture_run(1'b1, 1'b0);
      for (int t = 0; t <= RUN_LEN + 2; t++) begin
         n_cmp++;
         if ((obs[t] & exp_m[t < RUN_LEN + 2 ? t : RUN_LEN + 1]) !==
             (exp_v[t < RUN_LEN + 2 ? t : RUN_LEN + 1] & exp_m[t < RUN_LEN + 2 ? t : RUN_LEN + 1])) begin
            n_fail++;
            $display("FAIL busy_start_cycle_%0d got %h expected %h", t, obs[t], exp_v[t < RUN_LEN + 2 ? t : RUN_LEN + 1]);
         end
      end
   endtask

   task automatic test_done_start();
      capture_run(1'b0, 1'b1);
      n_cmp++;
      if ((obs[RUN_LEN] & M_CTL) !== (exp_v[RUN_LEN] & M_CTL)) begin
         n_fail++;
         $display("FAIL done_cycle got %h expected %h", obs[RUN_LEN] & M_CTL, exp_v[RUN_LEN] & M_CTL);
      end
      n_cmp++;
      if ((obs[RUN_LEN + 1] & M_ALL) !== 32'h0) begin
         n_fail++;
         $display("FAIL start_at_done_ignored got %h expected 00000000", obs[RUN_LEN + 1]);
      end
      n_cmp++;
      if ((obs[RUN_LEN + 2] & exp_m[0]) !== (exp_v[0] & exp_m[0])) begin
         n_fail++;
         $display("FAIL start_after_done got %h expected %h", obs[RUN_LEN + 2] & exp_m[0], exp_v[0] & exp_m[0]);
      end
      repeat (RUN_LEN + 2) @(negedge clk);
      n_cmp++;
      if ((obs_now() & M_ALL) !== 32'h0) begin
         n_fail++;
         $display("FAIL second_run_idle got %h expected 00000000", obs_now());
      end
   endtask

   task automatic test_reset_mid();
      int target;
      target = 84 + 5 * int'($urandom_range(0, 7)) + 3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (target) @(negedge clk);
      n_cmp++;
      if ((obs_now() & exp_m[target]) !== (exp_v[target] & exp_m[target])) begin
         n_fail++;
         $display("FAIL pre_reset_cycle_%0d got %h expected %h", target, obs_now() & exp_m[target], exp_v[target] & exp_m[target]);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ((obs_now() & M_ALL) !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs got %h expected 00000000", obs_now());
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ((obs_now() & M_ALL) !== 32'h0) begin
         n_fail++;
         $display("FAIL post_reset_idle got %h expected 00000000", obs_now());
      end
      capture_run(1'b0, 1'b0);
      for (int t = 0; t <= RUN_LEN + 1; t++) begin
         n_cmp++;
         if ((obs[t] & exp_m[t]) !== (exp_v[t] & exp_m[t])) begin
            n_fail++;
            $display("FAIL rerun_cycle_%0d got %h expected %h", t, obs[t], exp_v[t]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         capture_run(1'b0, 1'b0);
         for (int t = 0; t <= RUN_LEN + 1; t++) begin
            n_cmp++;
            if ((obs[t] & exp_m[t]) !== (exp_v[t] & exp_m[t])) begin
               n_fail++;
               $display("FAIL b2b_run%0d_cycle_%0d got %h expected %h", r, t, obs[t], exp_v[t]);
            end
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      start  = 1'b0;
      build_model();
      test_reset();
      test_full_run();
      test_start_while_busy();
      test_done_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
